bch_chien_sched: RTL and testbench

Round-robin scheduler that shares one `bch_error` Chien-search engine between `R` decoder channels. It accepts an error-locator polynomial (sigma) from one requester at a time and pulses the engine's `start`. It then streams the engine's per-bit `err` output downstream with a requester tag and first/last markers, and applies downstream backpressure through the engine's `accepted` input. It sits between the per-channel Berlekamp-Massey stages and the shared correction/XOR stage.

---
 rtl/bch_sched_pkg.sv | 15 +
 rtl/bch_rr_arb.sv | 36 +++
 rtl/bch_chien_sched.sv | 126 ++++++++++++
 tb/tb_bch_chien_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_sched_pkg.sv
// Shared types and width helpers for the Chien-search scheduler.
package bch_sched_pkg;

    typedef enum logic [2:0] {IDLE, START, WAIT, STREAM, DRAIN} sched_state_t;

    function automatic int iw_f(input int r);
        return (r <= 1) ? 1 : $clog2(r);
    endfunction

    // Wide enough to hold 0..k, used for both the beat and error counters.
    function automatic int cnt_w_f(input int k);
        return (k < 1) ? 1 : $clog2(k + 1);
    endfunction

endpackage

// File: rtl/bch_rr_arb.sv
// Combinational round-robin arbiter: first asserted request searching upward from ptr+1.
module bch_rr_arb
    import bch_sched_pkg::*;
#(
    parameter  int R  = 2,
    localparam int IW = iw_f(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [R-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    // Scan farthest-first so the nearest request after ptr is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = R; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % R]) begin
                w_found = 1'b1;
                w_idx   = IW'((int'(ptr) + k) % R);
            end
        end
        gnt     = '0;
        gnt_idx = '0;
        if (en && w_found) begin
            gnt[w_idx] = 1'b1;
            gnt_idx    = w_idx;
        end
    end

endmodule

// File: rtl/bch_chien_sched.sv
// Shares one Chien-search engine among R channels; grant->eng_start is 1 cycle, beats pass through
// combinationally with out_ready stalling the engine via eng_accepted. Define BCH_SCHED_ERRCNT_EN for out_errcnt.
module bch_chien_sched
    import bch_sched_pkg::*;
#(
    parameter  int M     = 4,
    parameter  int K     = 5,
    parameter  int T     = 3,
    parameter  int R     = 2,
    localparam int SW    = M * (T + 1),
    localparam int IW    = iw_f(R),
    localparam int CW    = cnt_w_f(K),
    localparam int BEATS = K
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [R-1:0]    req_valid,
    input  logic [R*SW-1:0] req_sigma,
    output logic [R-1:0]    req_ready,
    output logic            eng_start,
    output logic [SW-1:0]   eng_sigma,
    input  logic            eng_busy,
    input  logic            eng_ready,
    input  logic            eng_valid,
    input  logic            eng_err,
    output logic            eng_accepted,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_err,
    output logic [IW-1:0]   out_id,
    output logic            out_first,
    output logic            out_last
`ifdef BCH_SCHED_ERRCNT_EN
    ,
    output logic [CW-1:0]   out_errcnt
`endif
);

    sched_state_t  r_state, w_next;
    logic [IW-1:0] r_ptr, r_id, w_gnt_idx;
    logic [SW-1:0] r_sigma;
    logic [CW-1:0] r_beat;
    logic          r_vld_q;
    logic [R-1:0]  w_gnt;
    logic          w_arb_en, w_stream, w_hs, w_last, w_fall;

    // The engine has no reset, so a grant also waits for it to be fully drained.
    assign w_arb_en = !reset && (r_state == IDLE) && !eng_busy && !eng_valid;

    bch_rr_arb #(.R(R)) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_stream = (r_state == STREAM);
    assign w_hs     = w_stream && eng_valid && out_ready;
    assign w_last   = w_stream && (r_beat == CW'(BEATS - 1));
    assign w_fall   = w_stream && r_vld_q && !eng_valid;

    assign req_ready    = w_gnt;
    assign eng_start    = (r_state == START);
    assign eng_sigma    = r_sigma;
    assign eng_accepted = w_hs;
    assign out_valid    = w_stream && eng_valid;
    assign out_err      = w_stream && eng_err;
    assign out_first    = w_stream && (r_beat == '0);
    assign out_last     = w_last;
    assign out_id       = w_stream ? r_id : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_gnt) w_next = START;
            START:   w_next = WAIT;
            WAIT:    if (eng_ready) w_next = STREAM;
            STREAM:  if ((w_hs && w_last) || w_fall) w_next = DRAIN;
            DRAIN:   if (!eng_busy && !eng_valid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= IW'(R - 1);
            r_id    <= '0;
            r_sigma <= '0;
            r_beat  <= '0;
            r_vld_q <= 1'b0;
        end else begin
            r_state <= w_next;
            r_vld_q <= w_stream && eng_valid;
            if (|w_gnt) begin
                r_ptr   <= w_gnt_idx;
                r_id    <= w_gnt_idx;
                r_sigma <= req_sigma[int'(w_gnt_idx) * SW +: SW];
            end
            if (r_state == START) begin
                r_beat <= '0;
            end else if (w_hs) begin
                r_beat <= r_beat + CW'(1);
            end
        end
    end

`ifdef BCH_SCHED_ERRCNT_EN
    logic [CW-1:0] r_errcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_errcnt <= '0;
        end else if (r_state == START) begin
            r_errcnt <= '0;
        end else if (w_hs && eng_err) begin
            r_errcnt <= r_errcnt + CW'(1);
        end
    end

    // Include the beat currently on the bus so the total is complete on out_last.
    assign out_errcnt = out_valid ? (r_errcnt + CW'(eng_err)) : '0;
`endif

endmodule

// File: tb/tb_bch_chien_sched.sv
// Directed bench for bch_chien_sched with a behavioural Chien engine and a beat scoreboard.
module tb_bch_chien_sched;

    localparam int M  = 4;
    localparam int K  = 5;
    localparam int T  = 3;
    localparam int R  = 2;
    localparam int SW = M * (T + 1);
    localparam int IW = 1;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [R-1:0]    req_valid = '0;
    logic [R*SW-1:0] req_sigma;
    logic [R-1:0]    req_ready;
    logic            eng_start;
    logic [SW-1:0]   eng_sigma;
    logic            eng_busy = 1'b0;
    logic            eng_ready = 1'b0;
    logic            eng_valid = 1'b0;
    logic            eng_err = 1'b0;
    logic            eng_accepted;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_err;
    logic [IW-1:0]   out_id;
    logic            out_first;
    logic            out_last;
`ifdef BCH_SCHED_ERRCNT_EN
    logic [CW-1:0]   out_errcnt;
`endif

    logic [SW-1:0] sig [R];
    assign req_sigma = {sig[1], sig[0]};

    always #5 clk = ~clk;

    bch_chien_sched #(.M(M), .K(K), .T(T), .R(R)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_sigma    (req_sigma),
        .req_ready    (req_ready),
        .eng_start    (eng_start),
        .eng_sigma    (eng_sigma),
        .eng_busy     (eng_busy),
        .eng_ready    (eng_ready),
        .eng_valid    (eng_valid),
        .eng_err      (eng_err),
        .eng_accepted (eng_accepted),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_err      (out_err),
        .out_id       (out_id),
        .out_first    (out_first),
        .out_last     (out_last)
`ifdef BCH_SCHED_ERRCNT_EN
        ,
        .out_errcnt   (out_errcnt)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;
    int beats_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine model: err for bit j is sigma[j]; drains for a few cycles after the stream.
    logic [SW-1:0] e_sigma = '0;
    int  e_phase = 0;
    int  e_lat = 0;
    int  e_cnt = 0;
    int  drop_after = 0;
    bit  kill = 1'b0;

    always @(posedge clk) begin
        case (e_phase)
            0: if (eng_start) begin
                e_sigma  <= eng_sigma;
                eng_busy <= 1'b1;
                e_lat    <= 2;
                e_cnt    <= 0;
                e_phase  <= 1;
            end
            1: if (e_lat == 0) begin
                eng_ready <= 1'b1;
                e_phase   <= 2;
            end else begin
                e_lat <= e_lat - 1;
            end
            2: begin
                eng_ready <= 1'b0;
                eng_valid <= 1'b1;
                eng_err   <= e_sigma[0];
                e_phase   <= 3;
            end
            3: if (kill || (eng_accepted && (e_cnt + 1 == K || e_cnt + 1 == drop_after))) begin
                eng_valid <= 1'b0;
                eng_err   <= 1'b0;
                e_lat     <= 3;
                e_phase   <= 4;
            end else if (eng_accepted) begin
                e_cnt   <= e_cnt + 1;
                eng_err <= e_sigma[e_cnt + 1];
            end
            default: if (e_lat == 0) begin
                eng_busy <= 1'b0;
                e_phase  <= 0;
            end else begin
                e_lat <= e_lat - 1;
            end
        endcase
    end

    typedef struct {
        logic [IW-1:0] id;
        logic          err;
        logic          first;
        logic          last;
        int            cnt;
    } beat_t;

    beat_t sb[$];

    task automatic push_job(input int id, input logic [SW-1:0] s, input int nb);
        beat_t b;
        int    run = 0;
        for (int j = 0; j < nb; j++) begin
            run     += int'(s[j]);
            b.id    = IW'(id);
            b.err   = s[j];
            b.first = (j == 0);
            b.last  = (j == K - 1);
            b.cnt   = run;
            sb.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (out_valid) chk("accepted_vs_ready", eng_accepted, out_ready);
        else           chk("accepted_no_valid", eng_accepted, 0);
        if (|req_ready) chk("grant_engine_idle", {eng_busy, eng_valid}, 0);
        if (out_valid && out_ready) begin
            beats_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("beat_id", out_id, e.id);
                chk("beat_err", out_err, e.err);
                chk("beat_first", out_first, e.first);
                chk("beat_last", out_last, e.last);
`ifdef BCH_SCHED_ERRCNT_EN
                if (e.last) chk("errcnt_last", out_errcnt, e.cnt);
`endif
            end
        end
    end

    task automatic wait_grant(input int id, input bit drop, input int nb);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (|req_ready) seen = 1'b1;
        end
        chk("grant_seen", seen, 1);
        if (seen) begin
            chk("grant_onehot", req_ready, 32'(1) << id);
            chk("idle_outs", {out_valid, out_first, out_last, out_err, out_id}, 0);
            push_job(id, sig[id], nb);
            @(posedge clk); #1;
            if (drop) req_valid = '0;
            @(negedge clk);
            chk("start_pulse", eng_start, 1);
            chk("eng_sigma", eng_sigma, sig[id]);
            chk("start_outs", {out_valid, out_first, out_last, out_err, out_id, req_ready}, 0);
`ifdef BCH_SCHED_ERRCNT_EN
            chk("errcnt_start", out_errcnt, 0);
`endif
            @(negedge clk);
            chk("start_one_cycle", eng_start, 0);
        end
    endtask

    task automatic run_stream(input int mode);
        int i = 0;
        bit done = 1'b0;
        while (!done && i < 300) begin
            @(posedge clk); #1;
            out_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
            @(negedge clk); #1;
            if (sb.size() == 0) done = 1'b1;
            i++;
        end
        chk("stream_done", done, 1);
    endtask

    task automatic wait_engine_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            if (!eng_busy && !eng_valid) idle = 1'b1;
        end
        chk("engine_idle", idle, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        bit gone;
        sig[0] = 16'h3C15;
        sig[1] = 16'h5A13;
        req_valid = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {req_ready, eng_start, eng_accepted, out_valid, out_err, out_id, out_first, out_last}, 0);
        chk("reset_sigma", eng_sigma, 0);
        reset = 1'b0;

        // Single job on requester 0.
        wait_grant(0, 1'b1, K);
        run_stream(0);

        // Round robin with both requesters held valid.
        do_reset();
        req_valid = 2'b11;
        wait_grant(0, 1'b0, K); run_stream(0);
        wait_grant(1, 1'b0, K); run_stream(0);
        wait_grant(0, 1'b0, K); run_stream(0);
        wait_grant(1, 1'b1, K); run_stream(0);

        // Backpressure pattern 1,0,0,1.
        req_valid = 2'b10;
        wait_grant(1, 1'b1, K);
        run_stream(1);

        // Reset in the middle of a stream after three beats.
        wait_engine_idle();
        beats_seen = 0;
        req_valid = 2'b10;
        wait_grant(1, 1'b1, 3);
        for (int i = 0; i < 100 && beats_seen < 3; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk); #1;
        end
        chk("three_beats", beats_seen, 3);
        @(posedge clk); #1;
        out_ready = 1'b0;
        #1;
        chk("stalled_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("rst_outs", {req_ready, eng_start, eng_accepted, out_valid, out_err, out_id, out_first, out_last}, 0);
        chk("rst_sigma", eng_sigma, 0);
        chk("rst_sb_empty", sb.size(), 0);
        kill = 1'b1;
        gone = 1'b0;
        for (int i = 0; i < 50 && !gone; i++) begin
            @(negedge clk);
            if (!eng_valid) gone = 1'b1;
        end
        chk("engine_killed", gone, 1);
        kill = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("busy_after_rst", eng_busy, 1);
        req_valid = 2'b01;
        wait_grant(0, 1'b1, K);
        run_stream(0);

        // Engine drops valid after three beats.
        wait_engine_idle();
        drop_after = 3;
        req_valid = 2'b01;
        wait_grant(0, 1'b1, 3);
        run_stream(0);
        wait_engine_idle();
        drop_after = 0;
        req_valid = 2'b10;
        wait_grant(1, 1'b1, K);
        run_stream(0);

`ifdef BCH_SCHED_ERRCNT_EN
        wait_engine_idle();
        sig[0] = 16'h0015;
        req_valid = 2'b01;
        wait_grant(0, 1'b1, K);
        run_stream(0);
        req_valid = 2'b01;
        wait_grant(0, 1'b1, K);
        run_stream(0);
`endif

        wait_engine_idle();
        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_idle_outs", {req_ready, eng_start, out_valid, out_first, out_last}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
